// File: rtl/ff_pkg.sv
// Shared definitions for the flip-flop library cells.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ff_pkg;

  // Per-bit command, formed as {s, r}.
  typedef logic [1:0] ff_cmd_t;

  localparam ff_cmd_t CMD_HOLD = 2'b00;
  localparam ff_cmd_t CMD_CLR  = 2'b01;
  localparam ff_cmd_t CMD_SET  = 2'b10;
  localparam ff_cmd_t CMD_TGL  = 2'b11;

  // State loaded while reset is asserted.
  localparam logic FF_RST_VAL = 1'b0;

endpackage

// File: rtl/t_ff_cell.sv
// Single JK-style storage bit: hold / clear / set / toggle on {s, r}.
// Latency: one rising clk edge from command to q; reset clears q asynchronously.
// Backpressure: none, a command is consumed on every edge.
// Ports: clk, reset (async, active-high), s, r (commands), q, q_bar (true/complement).
module t_ff_cell
  import ff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (ff_cmd_t'({s, r}))
      CMD_HOLD: q_d = q_q;
      CMD_CLR:  q_d = 1'b0;
      CMD_SET:  q_d = 1'b1;
      CMD_TGL:  q_d = ~q_q;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= FF_RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Complement is derived from the same register so the pair can never disagree.
  assign q     = q_q;
  assign q_bar = ~q_q;

endmodule

// File: rtl/t_ff.sv
// Bank of WIDTH independent set/clear/toggle flip-flops sharing clk and reset.
// Latency: one rising clk edge from s/r to q; reset clears q asynchronously.
// Backpressure: none, commands are consumed on every edge.
// Ports: clk, reset (async, active-high), s[WIDTH], r[WIDTH], q[WIDTH], q_bar[WIDTH].
module t_ff
  import ff_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .s     (s[i]),
      .r     (r[i]),
      .q     (q[i]),
      .q_bar (q_bar[i])
    );
  end

endmodule

// File: tb/tb_t_ff.sv
module tb_t_ff;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] s;
  logic [W-1:0] r;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;

  int checks;
  int errors;

  t_ff #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s),
    .r     (r),
    .q     (q),
    .q_bar (q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [W-1:0] exp_q);
    logic [W-1:0] exp_qb;
    exp_qb = ~exp_q;
    checks++;
    if (q !== exp_q || q_bar !== exp_qb) begin
      errors++;
      $display("FAIL %s: q=%b q_bar=%b, required q=%b q_bar=%b at t=%0t",
               name, q, q_bar, exp_q, exp_qb, $time);
    end
  endtask

  // Drive a command on the falling edge, sample just after the next rising edge.
  task automatic step(input logic [W-1:0] s_v, input logic [W-1:0] r_v);
    @(negedge clk);
    s = s_v;
    r = r_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    // Hand-computed vectors, each applied for one edge in order.
    vecs[0]  = '{s: 4'b0000, r: 4'b1111, q: 4'b0000}; // clear
    vecs[1]  = '{s: 4'b1111, r: 4'b0000, q: 4'b1111}; // set
    vecs[2]  = '{s: 4'b0000, r: 4'b0000, q: 4'b1111}; // hold
    vecs[3]  = '{s: 4'b0000, r: 4'b0000, q: 4'b1111}; // hold
    vecs[4]  = '{s: 4'b0000, r: 4'b0000, q: 4'b1111}; // hold
    vecs[5]  = '{s: 4'b1111, r: 4'b1111, q: 4'b0000}; // toggle
    vecs[6]  = '{s: 4'b1111, r: 4'b1111, q: 4'b1111}; // toggle
    vecs[7]  = '{s: 4'b1111, r: 4'b1111, q: 4'b0000}; // toggle
    vecs[8]  = '{s: 4'b1111, r: 4'b1111, q: 4'b1111}; // toggle
    vecs[9]  = '{s: 4'b0011, r: 4'b1100, q: 4'b0011}; // mixed set/clear
    vecs[10] = '{s: 4'b1010, r: 4'b0110, q: 4'b1001}; // set/toggle/clear/hold
    vecs[11] = '{s: 4'b0101, r: 4'b0101, q: 4'b1100}; // toggle bits 0,2 only

    s = '0;
    r = '0;
    reset = 1'b1;

    // Reset state before and after the first rising edge.
    #1;
    chk("reset_before_edge", 4'b0000);
    #8;
    chk("reset_after_edge", 4'b0000);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].s, vecs[i].r);
      chk($sformatf("vec%0d", i), vecs[i].q);
    end

    // Toggle from 4'b1100, then assert reset in the high phase with no edge.
    step(4'b1111, 4'b1111);
    chk("toggle_before_reset", 4'b0011);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_mid_phase", 4'b0000);

    // Toggle command held while reset stays asserted across edges.
    @(posedge clk);
    #1;
    chk("reset_held_edge1", 4'b0000);
    @(posedge clk);
    #1;
    chk("reset_held_edge2", 4'b0000);

    // Release on a falling edge; toggling resumes at the next edge, first to 1.
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_released_no_edge", 4'b0000);
    @(posedge clk);
    #1;
    chk("toggle_resume_1", 4'b1111);
    @(posedge clk);
    #1;
    chk("toggle_resume_2", 4'b0000);

    // Reset asserted in the low phase also clears immediately.
    @(posedge clk);
    #1;
    chk("toggle_resume_3", 4'b1111);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_low_phase", 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
